rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Channel selection is automatic: round-robin by default, or fixed-priority when configured.
- The result is held in a single output register stage.
- Used wherever several producers share one datapath port, e.g. multiple sources competing for a shared bus or writeback path in the MIPS core.

Parameters:
- W, 32, data width per channel.
- N, 4, number of input channels (2..16).
- SEL_W, $clog2(N), width of the source index.
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority (channel 0 highest).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_ready  output  N  per-channel accept; a transfer on channel i occurs when in_valid[i] && in_ready[i] at a clk edge.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.
- out_data  output  W  registered data.
- out_src  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n==0 at a clk edge): out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
  - in_ready is all-zero while rst_n==0.
  - Reset mid-transfer discards the held beat. No input transfer is recorded on that edge.
- can_load = !out_valid || out_ready. This is combinational, so the block gives full throughput of 1 beat per cycle.
- Grant, combinational and one-hot:
  - g = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., ptr+N-1 modulo N.
  - No valid inputs → no grant.
- in_ready[i] = can_load && grant[i].
  - At most one in_ready bit is high.
  - in_ready never depends on in_data.
- On an edge with a grant and can_load:
  - out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - If RR=1: ptr <= (g+1) mod N, wrapping from N-1 to 0.
  - If RR=0: ptr stays 0.
- On an edge with out_valid && out_ready and no grant: out_valid <= 0. out_data and out_src hold their last values.
- On an edge with out_valid && !out_ready: all outputs and ptr hold (stall). in_ready is all-zero.
- Latency: 1 cycle from the accepted input edge to out_valid.
- Simultaneous drain and refill on the same edge: the new beat replaces the old one. No bubble, no loss.
- A requester may drop in_valid before it is granted. The grant is recomputed every cycle and no state is kept for ungranted requests.
- Fairness (RR=1): with all N channels continuously valid and out_ready=1, the grant order is 0,1,...,N-1,0,...
- N not a power of two: the pointer wraps at N, never at 2^SEL_W.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then all in_valid=0 → out_valid=0, out_data=0, out_src=0, in_ready=0000.
- Single source (W=32, N=4): in_valid=0100 with ch2=32'hCCCC_CCCC, out_ready=1 → on the next edge out_data=CCCC_CCCC, out_src=2, out_valid=1. Drop in_valid → out_valid=0 one cycle later.
- Round-robin: all four valid with ch0..3 = AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD and out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3, with matching data, one beat per cycle.
- Backpressure: out_ready=0 for 3 cycles with a beat held → out_data stable, in_ready=0000, ptr unchanged. Raise out_ready → the next grant follows the held out_src in RR order, with no beat lost or duplicated.
- Fixed priority (RR=0): in_valid=1010 for 4 cycles → out_src=1 on every beat. In_valid=1000 → out_src=3.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and all channels are valid → the next edge gives out_valid=0 and ptr=0. After release, the first grant is channel 0.
- Non-power-of-two N=3: all valid → out_src sequence 0,1,2,0, with no grant to index 3.

Source files
------------

// File: rtl/rr_arb_mux.sv
// ============================================================================
// rr_arb_mux
// ----------------------------------------------------------------------------
// N-channel, W-bit arbitrating multiplexer with a single registered output
// stage. Every input channel and the output use a valid/ready handshake.
//
// Arbitration:
//   RR=1 : round-robin. The scan starts at the priority pointer and wraps
//          modulo N. After each accepted beat the pointer moves one past the
//          winner.
//   RR=0 : fixed priority. The pointer stays at 0, so channel 0 always has
//          the highest priority.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   [N]      per-channel request (bit i = channel i)
//   in_ready   [N]      per-channel accept; at most one bit is high
//   in_data    [N*W]    packed channel data, channel i at [i*W +: W]
//   out_valid  1        output register holds a beat
//   out_ready  1        downstream accept
//   out_data   [W]      registered data
//   out_src    [SEL_W]  index of the channel that supplied out_data
// ============================================================================
module rr_arb_mux #(
    parameter int W     = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N),
    parameter int RR    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_src
);

    localparam int unsigned N_U   = N;
    localparam bit          RR_EN = (RR != 32'sd0);

    // Add an offset to a channel index, wrapping at N rather than at
    // 2^SEL_W. This keeps a non-power-of-two N from ever reaching an
    // index that does not exist. Both operands stay below N, so one
    // conditional subtraction is enough.
    function automatic logic [SEL_W-1:0] wrap_add(
        input logic [SEL_W-1:0] base,
        input int unsigned      offs
    );
        int unsigned sum_v;
        sum_v = 32'(base) + offs;
        if (sum_v >= N_U) begin
            sum_v = sum_v - N_U;
        end else begin
            sum_v = sum_v;
        end
        return sum_v[SEL_W-1:0];
    endfunction

    logic [SEL_W-1:0] ptr_r;
    logic             out_valid_r;
    logic [W-1:0]     out_data_r;
    logic [SEL_W-1:0] out_src_r;

    logic [N-1:0]     grant_s;
    logic [SEL_W-1:0] gidx_s;
    logic [SEL_W-1:0] cand_s;
    logic             found_s;
    logic             can_load_s;
    logic [W-1:0]     sel_data_s;

    // The output register can take a new beat when it is empty or is
    // being drained on this same edge. Draining and refilling together
    // gives one beat per cycle.
    assign can_load_s = !out_valid_r || out_ready;

    // Scan from the pointer for the first requesting channel and build a
    // one-hot grant. No state is kept for a channel that is not granted.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int unsigned k = 0; k < N_U; k++) begin
            cand_s = wrap_add(ptr_r, k);
            if (!found_s && in_valid[cand_s]) begin
                grant_s[cand_s] = 1'b1;
                gidx_s          = cand_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // AND-OR data mux driven by the one-hot grant.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            sel_data_s = sel_data_s | ({W{grant_s[i]}} & in_data[i*W +: W]);
        end
    end

    // Per-channel accept. This is gated low during reset so that no
    // transfer is seen on a reset edge. It never looks at in_data.
    always_comb begin
        if (!rst_n) begin
            in_ready = '0;
        end else begin
            in_ready = {N{can_load_s}} & grant_s;
        end
    end

    // Output register and priority pointer. A load takes precedence over a
    // plain drain. With out_valid set and out_ready low, every register
    // holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
            ptr_r       <= '0;
        end else if (can_load_s && found_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_src_r   <= gidx_s;
            if (RR_EN) begin
                ptr_r <= wrap_add(gidx_s, 32'd1);
            end else begin
                ptr_r <= '0;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_src_r   <= out_src_r;
            ptr_r       <= ptr_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_src_r   <= out_src_r;
            ptr_r       <= ptr_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_rr_arb_mux.sv
// ============================================================================
// tb_rr_arb_mux
// ----------------------------------------------------------------------------
// Testbench for rr_arb_mux. It uses three instances:
//   u4 : N=4, round-robin
//   up : N=4, fixed priority
//   u3 : N=3, round-robin
// Directed stimulus pushes the hand-computed {src, data} of each beat into a
// per-instance queue. A negedge monitor pops an entry and compares it
// whenever an instance presents a beat that downstream accepts.
// ============================================================================
module tb_rr_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [3:0]   vld4, ir4;
    logic [127:0] dat4;
    logic         ordy4, ov4;
    logic [31:0]  od4;
    logic [1:0]   os4;

    logic [3:0]   vldp, irp;
    logic [127:0] datp;
    logic         ordyp, ovp;
    logic [31:0]  odp;
    logic [1:0]   osp;

    logic [2:0]   vld3, ir3;
    logic [95:0]  dat3;
    logic         ordy3, ov3;
    logic [31:0]  od3;
    logic [1:0]   os3;

    logic [33:0] q4[$];
    logic [33:0] qp[$];
    logic [33:0] q3[$];
    logic [33:0] mon_e;

    logic [31:0] w4 [4];
    logic [31:0] w3 [3];

    int checks = 0;
    int errors = 0;

    rr_arb_mux #(.W(32), .N(4), .RR(1)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld4), .in_ready(ir4), .in_data(dat4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_src(os4)
    );

    rr_arb_mux #(.W(32), .N(4), .RR(0)) up (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vldp), .in_ready(irp), .in_data(datp),
        .out_valid(ovp), .out_ready(ordyp), .out_data(odp), .out_src(osp)
    );

    rr_arb_mux #(.W(32), .N(3), .RR(1)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(vld3), .in_ready(ir3), .in_data(dat3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_src(os3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard monitor: pops and compares every beat accepted downstream.
    always @(negedge clk) begin
        if (rst_n && ov4 && ordy4) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_u4: got unexpected beat %h expected none", {os4, od4});
            end else begin
                mon_e = q4.pop_front();
                chk("beat_u4", 64'({os4, od4}), 64'(mon_e));
            end
        end
        if (rst_n && ovp && ordyp) begin
            if (qp.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_up: got unexpected beat %h expected none", {osp, odp});
            end else begin
                mon_e = qp.pop_front();
                chk("beat_up", 64'({osp, odp}), 64'(mon_e));
            end
        end
        if (rst_n && ov3 && ordy3) begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL beat_u3: got unexpected beat %h expected none", {os3, od3});
            end else begin
                mon_e = q3.pop_front();
                chk("beat_u3", 64'({os3, od3}), 64'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        w4[0] = 32'hAAAA_AAAA; w4[1] = 32'hBBBB_BBBB;
        w4[2] = 32'hCCCC_CCCC; w4[3] = 32'hDDDD_DDDD;
        w3[0] = 32'h0000_00A0; w3[1] = 32'h0000_00B1; w3[2] = 32'h0000_00C2;

        rst_n = 1'b0;
        vld4 = 4'b0; dat4 = 128'd0; ordy4 = 1'b1;
        vldp = 4'b0; datp = 128'd0; ordyp = 1'b1;
        vld3 = 3'b0; dat3 = 96'd0;  ordy3 = 1'b1;

        // ---- reset then idle ----
        tick();
        vld4 = 4'hF;
        mid();
        chk("ready_in_reset", 64'(ir4), 64'(4'b0000));
        tick();
        vld4 = 4'b0;
        mid();
        chk("rst_valid", 64'(ov4), 64'(1'b0));
        chk("rst_data", 64'(od4), 64'(32'h0));
        chk("rst_src", 64'(os4), 64'(2'd0));
        chk("rst_ready", 64'(ir4), 64'(4'b0000));
        chk("rst_valid_up", 64'(ovp), 64'(1'b0));
        chk("rst_valid_u3", 64'(ov3), 64'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        mid();
        chk("idle_valid", 64'(ov4), 64'(1'b0));
        chk("idle_ready", 64'(ir4), 64'(4'b0000));

        // ---- single source on channel 2 ----
        tick();
        dat4[95:64] = 32'hCCCC_CCCC;
        vld4 = 4'b0100;
        q4.push_back({2'd2, 32'hCCCC_CCCC});
        mid();
        chk("single_ready", 64'(ir4), 64'(4'b0100));
        tick();
        vld4 = 4'b0;
        mid();
        chk("single_valid", 64'(ov4), 64'(1'b1));
        tick();
        mid();
        chk("single_drain", 64'(ov4), 64'(1'b0));
        chk("single_hold_data", 64'(od4), 64'(32'hCCCC_CCCC));
        chk("single_hold_src", 64'(os4), 64'(2'd2));

        // ---- reset so the pointer is 0, then round-robin over 8 beats ----
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dat4 = {w4[3], w4[2], w4[1], w4[0]};
        vld4 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            q4.push_back({2'(i % 4), w4[i % 4]});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) vld4 = 4'b0;
            mid();
            chk("rr_one_per_cycle", 64'(ov4), 64'(1'b1));
        end
        tick();

        // ---- backpressure: hold channel 0 for 3 stalled cycles ----
        vld4 = 4'hF;
        q4.push_back({2'd0, w4[0]});
        q4.push_back({2'd1, w4[1]});
        tick();
        ordy4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_ready", 64'(ir4), 64'(4'b0000));
            chk("bp_valid", 64'(ov4), 64'(1'b1));
            chk("bp_data", 64'(od4), 64'(32'hAAAA_AAAA));
            chk("bp_src", 64'(os4), 64'(2'd0));
            tick();
        end
        ordy4 = 1'b1;
        mid();
        chk("bp_resume_grant", 64'(ir4), 64'(4'b0010));
        tick();
        vld4 = 4'b0;
        mid();
        tick();

        // ---- fixed priority instance ----
        datp = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        vldp = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            qp.push_back({2'd1, 32'h1111_1111});
        end
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("fp_ready_1010", 64'(irp), 64'(4'b0010));
            tick();
        end
        vldp = 4'b1000;
        qp.push_back({2'd3, 32'h3333_3333});
        mid();
        chk("fp_ready_1000", 64'(irp), 64'(4'b1000));
        tick();
        vldp = 4'b0;
        mid();
        tick();

        // ---- reset mid-stream (u4 pointer is 2 here) ----
        vld4 = 4'hF;
        ordy4 = 1'b0;
        tick();
        rst_n = 1'b0;
        ordy4 = 1'b1;
        mid();
        chk("mrst_held_valid", 64'(ov4), 64'(1'b1));
        chk("mrst_held_src", 64'(os4), 64'(2'd2));
        chk("mrst_ready", 64'(ir4), 64'(4'b0000));
        tick();
        mid();
        chk("mrst_valid", 64'(ov4), 64'(1'b0));
        chk("mrst_data", 64'(od4), 64'(32'h0));
        chk("mrst_src", 64'(os4), 64'(2'd0));
        tick();
        rst_n = 1'b1;
        q4.push_back({2'd0, w4[0]});
        q4.push_back({2'd1, w4[1]});
        mid();
        chk("post_rst_grant", 64'(ir4), 64'(4'b0001));
        tick();
        mid();
        tick();
        vld4 = 4'b0;
        mid();
        tick();

        // ---- N=3: pointer wraps at 3 ----
        dat3 = {w3[2], w3[1], w3[0]};
        vld3 = 3'b111;
        for (int i = 0; i < 6; i++) begin
            q3.push_back({2'(i % 3), w3[i % 3]});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) vld3 = 3'b0;
            mid();
            chk("n3_valid", 64'(ov3), 64'(1'b1));
        end
        tick();
        tick();
        mid();
        chk("n3_drain", 64'(ov3), 64'(1'b0));

        // every expected beat must have been seen
        chk("q4_empty", 64'(q4.size()), 64'(0));
        chk("qp_empty", 64'(qp.size()), 64'(0));
        chk("q3_empty", 64'(q3.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
